// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests and sequences precise MEM-stage exceptions
// (freeze, wait for data bus, one-cycle flush, redirect). Optional watchdog via PIPE_CTRL_WDT_EN.
module pipe_ctrl #(
  parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter int          WDT_LIMIT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        wdt_timeout_o
);

  typedef enum logic [1:0] {RUN, WAIT_BUS, FLUSH} state_t;

  state_t      state;
  logic [31:0] exc_pc;
  logic [5:0]  req_stall;
  logic        wdt_fire;
  logic        exc_take;
  logic [31:0] exc_target;

  function automatic logic [31:0] redirect_target(input logic [31:0] cause,
                                                  input logic [31:0] epc);
    if (cause == 32'hE)      return epc;
    else if (cause == 32'h1) return INT_VECTOR;
    else                     return EXC_VECTOR;
  endfunction

  always_comb begin
    req_stall = 6'b000000;
    if (stallreq_mem_i)     req_stall = 6'b011111;
    else if (stallreq_ex_i) req_stall = 6'b001111;
    else if (stallreq_id_i) req_stall = 6'b000111;
    else if (stallreq_if_i) req_stall = 6'b000111;
  end

  // A real cause always beats the watchdog; the watchdog redirects to EXC_VECTOR.
  assign exc_take   = (state == RUN) && ((excepttype_i != 32'h0) || wdt_fire);
  assign exc_target = (excepttype_i != 32'h0) ? redirect_target(excepttype_i, cp0_epc_i)
                                              : EXC_VECTOR;

  always_comb begin
    stall_o = 6'b000000;
    if (!rst) begin
      case (state)
        RUN:      stall_o = exc_take ? 6'b111111 : req_stall;
        WAIT_BUS: stall_o = 6'b111111;
        default:  stall_o = 6'b000000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      flush_o  <= 1'b0;
      new_pc_o <= 32'h0;
      exc_pc   <= 32'h0;
    end else begin
      flush_o <= 1'b0;
      case (state)
        RUN: begin
          if (exc_take) begin
            exc_pc <= exc_target;
            if (!stallreq_mem_i) begin
              state    <= FLUSH;
              flush_o  <= 1'b1;
              new_pc_o <= exc_target;
            end else begin
              state <= WAIT_BUS;
            end
          end
        end
        WAIT_BUS: begin
          if (!stallreq_mem_i) begin
            state    <= FLUSH;
            flush_o  <= 1'b1;
            new_pc_o <= exc_pc;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_WDT_EN
  localparam logic [15:0] WDT_LAST = 16'(WDT_LIMIT - 1);

  logic [15:0] wdt_cnt;
  logic        wdt_pend;
  logic        wdt_pulse;

  assign wdt_fire = (state == RUN) && (excepttype_i == 32'h0) &&
                    (req_stall != 6'b000000) && (wdt_cnt == WDT_LAST);

  // wdt_pend remembers that a bus-delayed redirect came from the watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt   <= 16'h0;
      wdt_pend  <= 1'b0;
      wdt_pulse <= 1'b0;
    end else begin
      wdt_pulse <= 1'b0;
      case (state)
        RUN: begin
          if (exc_take) begin
            wdt_cnt  <= 16'h0;
            wdt_pend <= wdt_fire;
            if (!stallreq_mem_i) wdt_pulse <= wdt_fire;
          end else if (req_stall != 6'b000000) begin
            wdt_cnt <= wdt_cnt + 16'h1;
          end else begin
            wdt_cnt <= 16'h0;
          end
        end
        WAIT_BUS: if (!stallreq_mem_i) wdt_pulse <= wdt_pend;
        default: begin
          wdt_cnt  <= 16'h0;
          wdt_pend <= 1'b0;
        end
      endcase
    end
  end

  assign wdt_timeout_o = wdt_pulse;
`else
  assign wdt_fire      = 1'b0;
  // Watchdog compiled out: output is constant 0 for any WDT_LIMIT.
  assign wdt_timeout_o = 1'b0 & (WDT_LIMIT != 0);
`endif

endmodule
